serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Multi-cycle two's-complement subtractor computing `a - b - bin` two bits per clock, least-significant slice first, with an explicit borrow chain between slices. It is the inverse-direction companion to the team's 2-bit ripple adder slice. It sits in the gate-level arithmetic library, where a registered, iterative datapath is preferred over a wide combinational one. A start/busy/done handshake lets a sequencer issue operations and collect results.

## Interface
- `WIDTH`, default 8: operand and result width in bits. Must be even and ≥ 2; any other value is an elaboration error.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request a new operation; sampled on the rising edge.
- `a` input WIDTH: minuend; sampled only on an accepted start.
- `b` input WIDTH: subtrahend; sampled only on an accepted start.
- `bin` input 1: borrow-in; sampled only on an accepted start.
- `busy` output 1: operation in progress; new starts are ignored while high.
- `done` output 1: one-cycle pulse marking the cycle when `diff` and `bout` first show a new result.
- `diff` output WIDTH: result `(a - b - bin) mod 2^WIDTH`.
- `bout` output 1: borrow-out; 1 exactly when `a < b + bin` (unsigned).

## Operation
- FSM states: IDLE, RUN.
  - IDLE → RUN on `start=1`. This latches `a`, `b`, `bin` into internal shift registers, sets the borrow register to `bin`, and sets the slice counter to 0.
  - RUN → IDLE after the last slice, when the counter reaches N-1, where N = WIDTH/2.
- Per RUN cycle, slice k covers bits 2k+1:2k. For each bit i, using the current borrow:
  - d_i = a_i ^ b_i ^ borrow
  - borrow' = (~a_i & b_i) | (~(a_i ^ b_i) & borrow)
  - Bit 2k+1 uses the borrow produced by bit 2k. The slice's final borrow is registered for slice k+1.
- Partial difference bits accumulate in an internal register.
- `diff` and `bout` are written only on the completing edge. They then hold until the next completion.
- `start` while `busy=1` is ignored. Operands are not resampled and no error is flagged.
- `start` in IDLE is accepted regardless of `done`. This allows back-to-back operation.

## Timing
- Reset (`rst_n=0`, asynchronous): state IDLE; `busy=0`, `done=0`, `diff=0`, `bout=0`. Counter, borrow, and shift registers are cleared.
- Reset asserted mid-operation aborts immediately. The in-flight result is discarded; no `done` is produced.
- After `rst_n` deasserts, the first rising edge with `start=1` is accepted.
- Latency, with the start accepted at edge E0:
  - `busy=1` from E0.
  - Slices are computed at edges E1..EN.
  - At EN: `done=1`, `busy=0`, and `diff`/`bout` are valid.
  - At E(N+1): `done=0`.
  - For WIDTH=8 the result appears 4 cycles after start.
- Throughput: one operation per N+1 cycles. `start` held high continuously yields back-to-back operations: a new start is accepted at E(N+1), and `done` pulses every N+1 cycles.
- `start` at EN is ignored, because `busy` is still high before that edge.
- `a`, `b`, `bin` may change freely after E0 without affecting the result.
- WIDTH=2: N=1. The operation completes at E1 with a single RUN cycle.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, bin=0, start pulsed at E0 → `busy` high E0..E3, `done` high only after E4, `diff`=0x1E, `bout`=0.
- a=0x00, b=0x01, bin=0 → `diff`=0xFF, `bout`=1. Then a=0xFF, b=0xFF, bin=1 → `diff`=0xFF, `bout`=1. Then a=0x80, b=0x7F, bin=1 → `diff`=0x00, `bout`=0.
- Start a=0x10, b=0x01; at E2 pulse `start` with a=0xAA, b=0x00 → second request ignored; `diff`=0x0F at E4; `busy` returns to 0 and stays 0.
- `start` held high for 3 operations with operands changed after each acceptance → `done` at E4, E9, E14, each with the correct result; `diff` holds between pulses.
- Start a=0x33, b=0x11; assert `rst_n=0` asynchronously between E2 and E3 → outputs go to 0 immediately; no `done`. After release, start a=0x02, b=0x03 → `diff`=0xFF, `bout`=1 after 4 cycles.
- Random regression for WIDTH=2, 8, 16 (≥1000 ops each) against the reference `{bout,diff} = {1'b0,a} - {1'b0,b} - bin`, with `done` exactly WIDTH/2 cycles after each accepted start.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor: iterative a - b - bin, two bits per clock,
// LSB slice first, with the borrow registered between slices.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int N  = WIDTH / 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
    $error("serial_subtractor: WIDTH must be even and >= 2");
  end

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nx;
  logic [WIDTH+1:0] acc_cat;
  logic [CW-1:0]    cnt;
  logic             brw;

  logic load;
  logic step;
  logic last;

  logic d0;
  logic d1;
  logic brw_mid;
  logic brw_out;

  assign last = (cnt == LAST);

  // two-bit borrow-ripple slice on the low bits of the shifters
  always_comb begin
    d0      = a_sh[0] ^ b_sh[0] ^ brw;
    brw_mid = (~a_sh[0] & b_sh[0])
            | (~(a_sh[0] ^ b_sh[0]) & brw);
    d1      = a_sh[1] ^ b_sh[1] ^ brw_mid;
    brw_out = (~a_sh[1] & b_sh[1])
            | (~(a_sh[1] ^ b_sh[1]) & brw_mid);
  end

  // new slice enters at the top; after N steps acc is LSB-aligned
  always_comb begin
    acc_cat = {d1, d0, acc};
    acc_nx  = acc_cat[WIDTH+1:2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    load = 1'b0;
    step = 1'b0;
    unique case (state)
      IDLE: begin
        load = start;
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      acc  <= '0;
      cnt  <= '0;
      brw  <= 1'b0;
      done <= 1'b0;
      diff <= '0;
      bout <= 1'b0;
    end else begin
      done <= step & last;
      if (load) begin
        a_sh <= a;
        b_sh <= b;
        acc  <= '0;
        cnt  <= '0;
        brw  <= bin;
      end else if (step) begin
        a_sh <= a_sh >> 2;
        b_sh <= b_sh >> 2;
        acc  <= acc_nx;
        cnt  <= cnt + CW'(1);
        brw  <= brw_out;
        if (last) begin
          diff <= acc_nx;
          bout <= brw_out;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench, one lane per WIDTH (2, 8, 16),
// arithmetic reference model and cycle-accurate latency expectations.
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  for (genvar l = 0; l < 3; l++) begin : g_lane
    localparam int W = (l == 0) ? 2 : (l == 1) ? 8 : 16;
    localparam int N = W / 2;

    typedef struct {
      logic [W:0] r;
      int         due;
    } exp_t;

    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         bin   = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic         bout;
    logic [W-1:0] diff;

    exp_t       q[$];
    int         acc_cyc = -100;
    int         nacc    = 0;
    logic [W:0] held    = '0;
    bit         fin     = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout)
    );

    // accept rule: idle once N+1 edges have passed since last accept
    always @(posedge clk) begin : push
      int e;
      logic [W:0] rv;
      e = cyc;
      if (rst_n && start && (e > acc_cyc + N)) begin
        rv = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        acc_cyc = e;
        nacc++;
        q.push_back('{r: rv, due: e + N});
      end
    end

    always @(negedge rst_n) begin
      q.delete();
      acc_cyc = -100;
      held = '0;
    end

    always @(negedge clk) begin : mon
      int e;
      logic [W:0] outv;
      e = cyc - 1;
      outv = {bout, diff};
      if (!rst_n) begin
        chk($sformatf("w%0d reset outputs", W),
            {busy, done, outv}, '0);
      end else begin
        chk($sformatf("w%0d busy e=%0d", W, e), busy,
            (e >= acc_cyc) && (e < acc_cyc + N));
        if ((q.size() > 0) && (q[0].due == e)) begin
          chk($sformatf("w%0d done e=%0d", W, e), done, 1);
          held = q[0].r;
          void'(q.pop_front());
        end else begin
          chk($sformatf("w%0d no done e=%0d", W, e), done, 0);
        end
        chk($sformatf("w%0d {bout,diff} e=%0d", W, e), outv, held);
      end
    end

    task automatic set_ops(logic [15:0] aa, logic [15:0] bb,
                           logic bi);
      a   = W'(aa);
      b   = W'(bb);
      bin = bi;
    endtask

    task automatic op_pulse(logic [15:0] aa, logic [15:0] bb,
                            logic bi);
      @(posedge clk);
      #1;
      set_ops(aa, bb, bi);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      set_ops(16'($urandom), 16'($urandom), 1'($urandom));
      repeat (N + 1) @(posedge clk);
      #1;
    endtask

    initial begin : stim
      int base;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      op_pulse(16'h5A, 16'h3C, 1'b0);
      op_pulse(16'h00, 16'h01, 1'b0);
      op_pulse(16'hFF, 16'hFF, 1'b1);
      op_pulse(16'h80, 16'h7F, 1'b1);

      // second request lands while busy and is dropped
      @(posedge clk);
      #1 set_ops(16'h10, 16'h01, 1'b0);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      #1 set_ops(16'hAA, 16'h00, 1'b0);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (N + 3) @(posedge clk);

      // start held high: back-to-back operations
      #1 set_ops(16'($urandom), 16'($urandom), 1'($urandom));
      start = 1'b1;
      repeat (3) begin
        @(posedge clk);
        #1 set_ops(16'($urandom), 16'($urandom), 1'($urandom));
        repeat (N) @(posedge clk);
      end
      #1 start = 1'b0;
      repeat (N + 2) @(posedge clk);

      // asynchronous abort mid-operation
      #1 set_ops(16'h33, 16'h11, 1'b0);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b0;
      #1 chk($sformatf("w%0d async abort", W),
             {busy, done, bout, diff}, '0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      op_pulse(16'h02, 16'h03, 1'b0);

      base = nacc;
      for (int i = 0; (i < 40000) && (nacc - base < 1000); i++) begin
        @(posedge clk);
        #1;
        start = ($urandom_range(0, 3) != 0);
        set_ops(16'($urandom), 16'($urandom), 1'($urandom));
      end
      chk($sformatf("w%0d random op budget", W),
          (nacc - base) >= 1000, 1);
      start = 1'b0;
      repeat (N + 3) @(posedge clk);
      #1 chk($sformatf("w%0d pending results", W), q.size(), 0);
      fin = 1'b1;
    end
  end

  initial begin : main
    bit all_fin;
    all_fin = 1'b0;
    for (int k = 0; (k < 60000) && !all_fin; k++) begin
      @(posedge clk);
      all_fin = g_lane[0].fin && g_lane[1].fin && g_lane[2].fin;
    end
    chk("all lanes finished", all_fin, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
